// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and access-legality helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } lsu_state_t;

    function automatic logic isMisaligned(input logic [2:0] funct3, input logic [1:0] offset);
        logic mis;
        mis = 1'b0;
        case (funct3)
            F3_H, F3_HU: mis = offset[0];
            F3_W:        mis = (offset != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Stores only have B/H/W; loads additionally have BU/HU.
    function automatic logic isUnsupported(input logic we, input logic [2:0] funct3);
        logic bad;
        if (we) begin
            bad = (funct3 != F3_B) && (funct3 != F3_H) && (funct3 != F3_W);
        end else begin
            bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic: extracts and extends load data from a memory word,
// and merges sub-word store data into a memory word.
module lsu_lane
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        funct3,
    input  logic [1:0]        offset,
    input  logic [DATA_W-1:0] rword,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] loadData,
    output logic [DATA_W-1:0] mergeWord
);

    logic        [7:0]  byteSel;
    logic        [15:0] halfSel;
    logic signed [7:0]  byteS;
    logic signed [15:0] halfS;

    always_comb begin
        byteSel = 8'h00;
        case (offset)
            2'd0:    byteSel = rword[7:0];
            2'd1:    byteSel = rword[15:8];
            2'd2:    byteSel = rword[23:16];
            default: byteSel = rword[31:24];
        endcase
    end

    // Halfword lane ignores offset[0]; a misaligned request never reaches here in trap builds.
    assign halfSel = offset[1] ? rword[31:16] : rword[15:0];
    assign byteS   = byteSel;
    assign halfS   = halfSel;

    always_comb begin
        loadData = rword;
        case (funct3)
            F3_B:    loadData = DATA_W'(byteS);
            F3_H:    loadData = DATA_W'(halfS);
            F3_BU:   loadData = {{(DATA_W-8){1'b0}}, byteSel};
            F3_HU:   loadData = {{(DATA_W-16){1'b0}}, halfSel};
            default: loadData = rword;
        endcase
    end

    always_comb begin
        mergeWord = wdata;
        case (funct3)
            F3_B: begin
                mergeWord = rword;
                case (offset)
                    2'd0:    mergeWord[7:0]   = wdata[7:0];
                    2'd1:    mergeWord[15:8]  = wdata[7:0];
                    2'd2:    mergeWord[23:16] = wdata[7:0];
                    default: mergeWord[31:24] = wdata[7:0];
                endcase
            end
            F3_H: begin
                mergeWord = rword;
                if (offset[1]) mergeWord[31:16] = wdata[15:0];
                else           mergeWord[15:0]  = wdata[15:0];
            end
            default: mergeWord = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Word-level memory initiator for RV32I loads/stores with sub-word RMW.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned accesses with rsp_err.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_t        state, stateNext;
    logic              errQ;
    logic              weQ;
    logic [2:0]        funct3Q;
    logic [ADDR_W-1:0] addrQ;
    logic [DATA_W-1:0] wdataQ;
    logic [DATA_W-1:0] wordQ;
    logic [DATA_W-1:0] loadData;
    logic [DATA_W-1:0] mergeWord;
    logic              acceptErr;
    logic              accept;

`ifdef LSU_MISALIGN_TRAP_EN
    assign acceptErr = isUnsupported(req_we, req_funct3) || isMisaligned(req_funct3, req_addr[1:0]);
`else
    assign acceptErr = isUnsupported(req_we, req_funct3);
`endif

    assign accept = req_valid && (state == S_IDLE);

    lsu_lane #(.DATA_W(DATA_W)) uLane (
        .funct3    (funct3Q),
        .offset    (addrQ[1:0]),
        .rword     (mem_rdata),
        .wdata     (wdataQ),
        .loadData  (loadData),
        .mergeWord (mergeWord)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            errQ  <= 1'b0;
        end else begin
            state <= stateNext;
            if (accept) errQ <= acceptErr;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (acceptErr)                        stateNext = S_RESP;
                    else if (req_we && req_funct3 == F3_W) stateNext = S_WRITE;
                    else                                  stateNext = S_READ;
                end
            end
            S_READ:  stateNext = weQ ? S_WRITE : S_RESP;
            S_WRITE: stateNext = S_RESP;
            default: stateNext = S_IDLE;
        endcase
    end

    // Request capture and read-cycle result; outputs are gated by state, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            weQ     <= req_we;
            funct3Q <= req_funct3;
            addrQ   <= req_addr;
            wdataQ  <= req_wdata;
            wordQ   <= req_wdata;
        end else if (state == S_READ) begin
            wordQ <= weQ ? mergeWord : loadData;
        end
    end

    always_comb begin
        req_ready = (state == S_IDLE);
        rsp_valid = (state == S_RESP);
        rsp_err   = (state == S_RESP) && errQ;
        rsp_rdata = '0;
        mem_adr   = '0;
        mem_wdata = '0;
        mem_write = 1'b0;
        if (state == S_RESP && !errQ && !weQ) rsp_rdata = wordQ;
        if (state == S_READ || state == S_WRITE) mem_adr = {addrQ[ADDR_W-1:2], 2'b00};
        if (state == S_WRITE) begin
            mem_wdata = wordQ;
            // Reset during WRITE must keep the memory from committing on that edge.
            mem_write = rst_n;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a word-addressed memory model.
module tb_load_store_unit;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nWr;
        int          wLat;
        logic [31:0] wData;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_adr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:63];
    exp_t        sbq[$];
    int          nCmp = 0;
    int          nFail = 0;
    int          cyc = 0;
    int          acceptCyc = 0;
    int          writeCount = 0;
    int          writeLat = 0;
    logic [31:0] writeData = '0;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_adr[7:2]];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_write) mem[mem_adr[7:2]] <= mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] rdata, input logic err, input int lat,
                                input int nWr, input int wLat, input logic [31:0] wData);
        exp_t e;
        e.rdata = rdata; e.err = err; e.lat = lat;
        e.nWr = nWr; e.wLat = wLat; e.wData = wData;
        return e;
    endfunction

    // Monitor: records write cycles and checks every response against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && mem_write) begin
            writeCount++;
            writeLat  = cyc - acceptCyc + 1;
            writeData = mem_wdata;
            check("wr_adr_hi", 32'(mem_adr[31:8]), 32'h0);
        end
        if (rsp_valid) begin
            if (sbq.size() == 0) begin
                check("unexpected_rsp", 32'(rsp_valid), 32'h0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", 32'(rsp_err), 32'(e.err));
                check("rsp_latency", 32'(cyc - acceptCyc + 1), 32'(e.lat));
                check("rsp_ready_low", 32'(req_ready), 32'h0);
                check("write_count", 32'(writeCount), 32'(e.nWr));
                if (e.nWr > 0) begin
                    check("write_cycle", 32'(writeLat), 32'(e.wLat));
                    check("write_data", writeData, e.wData);
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input exp_t e, input logic push);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) check("accept_timeout", 32'(req_ready), 32'h1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        acceptCyc  = cyc;
        writeCount = 0;
        if (push) sbq.push_back(e);
        req_valid = 1'b0;
    endtask

    task automatic waitDone();
        int guard;
        guard = 0;
        while (sbq.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (sbq.size() != 0) begin
            check("rsp_timeout", 32'(sbq.size()), 32'h0);
            sbq.delete();
        end
        @(negedge clk);
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'h0);
        check({tag, "_mem_write"}, 32'(mem_write), 32'h0);
        check({tag, "_mem_adr"}, mem_adr, 32'h0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    endtask

    initial begin
        exp_t none;
        int   errAccept;
        none = mk(32'h0, 1'b0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4] = 32'h8899AABB;
        mem[8] = 32'h11223344;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(req_ready), 32'h1);

        issue(1'b0, 3'b000, 32'h11, 32'h0, mk(32'hFFFFFFAA, 1'b0, 2, 0, 0, 0), 1'b1); waitDone();
        issue(1'b0, 3'b100, 32'h13, 32'h0, mk(32'h00000088, 1'b0, 2, 0, 0, 0), 1'b1); waitDone();
        issue(1'b0, 3'b001, 32'h12, 32'h0, mk(32'hFFFF8899, 1'b0, 2, 0, 0, 0), 1'b1); waitDone();
        issue(1'b0, 3'b101, 32'h10, 32'h0, mk(32'h0000AABB, 1'b0, 2, 0, 0, 0), 1'b1); waitDone();
        issue(1'b0, 3'b010, 32'h10, 32'h0, mk(32'h8899AABB, 1'b0, 2, 0, 0, 0), 1'b1); waitDone();
        issue(1'b0, 3'b110, 32'h10, 32'h0, mk(32'h0, 1'b1, 1, 0, 0, 0), 1'b1); waitDone();
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b0, 3'b010, 32'h12, 32'h0, mk(32'h0, 1'b1, 1, 0, 0, 0), 1'b1); waitDone();
        issue(1'b0, 3'b001, 32'h11, 32'h0, mk(32'h0, 1'b1, 1, 0, 0, 0), 1'b1); waitDone();
`else
        issue(1'b0, 3'b010, 32'h12, 32'h0, mk(32'h8899AABB, 1'b0, 2, 0, 0, 0), 1'b1); waitDone();
        issue(1'b0, 3'b001, 32'h11, 32'h0, mk(32'hFFFFAABB, 1'b0, 2, 0, 0, 0), 1'b1); waitDone();
`endif

        // SH with reset asserted during READ: the write must never happen.
        issue(1'b1, 3'b001, 32'h10, 32'h00001234, none, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkResetOutputs("rst_in_read");
        check("rst_in_read_ready", 32'(req_ready), 32'h1);
        check("rst_in_read_mem", mem[4], 32'h8899AABB);
        check("rst_in_read_writes", 32'(writeCount), 32'h0);
        rst_n = 1'b1;

        // SW with reset asserted during WRITE: the write on that edge is suppressed.
        issue(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, none, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkResetOutputs("rst_in_write");
        check("rst_in_write_mem", mem[8], 32'h11223344);
        rst_n = 1'b1;

        issue(1'b1, 3'b000, 32'h12, 32'h00000055, mk(32'h0, 1'b0, 3, 1, 2, 32'h8855AABB), 1'b1); waitDone();
        check("sb_mem_word", mem[4], 32'h8855AABB);
        issue(1'b0, 3'b010, 32'h10, 32'h0, mk(32'h8855AABB, 1'b0, 2, 0, 0, 0), 1'b1); waitDone();
        issue(1'b1, 3'b010, 32'h24, 32'hCAFEF00D, mk(32'h0, 1'b0, 2, 1, 1, 32'hCAFEF00D), 1'b1); waitDone();
        check("sw_mem_word", mem[9], 32'hCAFEF00D);

        // Unsupported store funct3 followed immediately by a load.
        issue(1'b1, 3'b011, 32'h10, 32'hFFFFFFFF, mk(32'h0, 1'b1, 1, 0, 0, 0), 1'b1);
        errAccept = acceptCyc;
        issue(1'b0, 3'b010, 32'h10, 32'h0, mk(32'h8855AABB, 1'b0, 2, 0, 0, 0), 1'b1);
        check("back_to_back_accept", 32'(acceptCyc - errAccept), 32'h2);
        waitDone();
        check("err_store_mem", mem[4], 32'h8855AABB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
        $fatal(1);
    end

endmodule
